// File: rtl/jreg_xfer_ctrl.sv
// jreg_xfer_ctrl
//   Sequencer/arbiter for a bank of N2 bus registers sharing one bus. Accepts
//   register-to-register move requests from two requesters (round-robin on
//   contention) and steps the bank through: enable src, set dst, release set.
//   The enable is held one cycle past the set so the latching register sees
//   stable bus data on both sides of its set pulse.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   reqX_valid/src/dst      requester X transfer request (held until ready)
//   reqX_ready              requester X accepted this cycle (IDLE only)
//   we                      one-hot register output-enable to bus
//   ws                      one-hot register set (latch from bus)
//   busy                    transfer in progress
//   done, done_id           final-cycle pulse and owning requester
module jreg_xfer_ctrl #(
  parameter int N  = 2,
  parameter int N2 = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [N-1:0]  req0_src,
  input  logic [N-1:0]  req0_dst,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [N-1:0]  req1_src,
  input  logic [N-1:0]  req1_dst,
  output logic          req1_ready,
  output logic [N2-1:0] we,
  output logic [N2-1:0] ws,
  output logic          busy,
  output logic          done,
  output logic          done_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENABLE,
    S_SET,
    S_RELEASE
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] src_q, src_d;
  logic [N-1:0] dst_q, dst_d;
  logic         id_q, id_d;
  logic         last_q, last_d;   // requester granted most recently
  logic         grant_any;
  logic         grant_id;
  logic [N2-1:0] src_oh;
  logic [N2-1:0] dst_oh;

  // Arbitration: only evaluated in IDLE; on contention the requester not
  // granted last wins. Reset suppresses any acceptance.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!reset && state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_q;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any &  grant_id;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = S_ENABLE;
          src_d   = grant_id ? req1_src : req0_src;
          dst_d   = grant_id ? req1_dst : req0_dst;
          id_d    = grant_id;
          last_d  = grant_id;
        end
      end
      S_ENABLE:  state_d = S_SET;
      S_SET:     state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Moore decode from registered state and captured indices only.
  always_comb begin
    src_oh        = '0;
    dst_oh        = '0;
    src_oh[src_q] = 1'b1;
    dst_oh[dst_q] = 1'b1;
  end

  always_comb begin
    we = '0;
    ws = '0;
    case (state_q)
      S_ENABLE:  we = src_oh;
      S_SET: begin
        we = src_oh;
        // A self-move must not latch the register onto its own output.
        if (src_q != dst_q) ws = dst_oh;
      end
      S_RELEASE: we = src_oh;
      default: begin
        we = '0;
        ws = '0;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_RELEASE);
  assign done_id = id_q;

endmodule

// File: tb/tb_jreg_xfer_ctrl.sv
// Testbench for jreg_xfer_ctrl: two configurations (N=2 and N=3) each driven
// by randomized requesters, with a behavioural arbitration/timing model that
// pushes expected transfers into a scoreboard queue and a monitor that checks
// we/ws/busy/done/done_id every cycle against the queue head.
module tb_jreg_xfer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int id;
    int src;
    int dst;
    int acc;   // cycle in which ready was high
  } xfer_t;

  function automatic void chk(int ncfg, string nm, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL N=%0d %s actual=%0h required=%0h @%0t", ncfg, nm, act, expv, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NG  = 2 + g;
    localparam int NG2 = 1 << NG;

    logic           rst;
    logic           v0, v1, r0, r1;
    logic [NG-1:0]  s0, d0, s1, d1;
    logic [NG2-1:0] we, ws;
    logic           busy, done, done_id;
    int             cyc = 0;
    bit             fin = 1'b0;
    xfer_t          q[$];

    jreg_xfer_ctrl #(.N(NG), .N2(NG2)) dut (
      .clk        (clk),
      .reset      (rst),
      .req0_valid (v0),
      .req0_src   (s0),
      .req0_dst   (d0),
      .req0_ready (r0),
      .req1_valid (v1),
      .req1_src   (s1),
      .req1_dst   (d1),
      .req1_ready (r1),
      .we         (we),
      .ws         (ws),
      .busy       (busy),
      .done       (done),
      .done_id    (done_id)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus + reference model of arbitration and acceptance timing.
    initial begin : stim
      int  ptr;
      int  next_idle;
      int  last_acc;
      int  p;
      bit  pend0, pend1, g0, g1;
      xfer_t it;
      rst = 1'b1;
      v0 = 1'b0; v1 = 1'b0;
      s0 = '0; d0 = '0; s1 = '0; d1 = '0;
      pend0 = 1'b0; pend1 = 1'b0;
      ptr = 1; next_idle = 0; last_acc = -100;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      next_idle = cyc;
      for (int i = 0; i < 400; i++) begin
        p = (i < 40) ? 100 : 35;
        if (!pend0) begin
          v0 = ($urandom_range(99) < p);
          pend0 = v0;
          s0 = NG'($urandom);
          d0 = NG'($urandom);
        end
        if (!pend1) begin
          v1 = ($urandom_range(99) < p);
          pend1 = v1;
          s1 = NG'($urandom);
          d1 = NG'($urandom);
        end
        // Occasionally reset in the middle of the set step.
        rst = (i >= 40) && (cyc == last_acc + 2) && ($urandom_range(99) < 20);
        @(negedge clk);
        g0 = 1'b0; g1 = 1'b0;
        if (!rst && cyc >= next_idle) begin
          if (v0 && v1) begin
            if (ptr == 1) g0 = 1'b1; else g1 = 1'b1;
          end else if (v0) g0 = 1'b1;
          else if (v1) g1 = 1'b1;
        end
        chk(NG, "req0_ready", r0, g0);
        chk(NG, "req1_ready", r1, g1);
        if (g0 || g1) begin
          it.id  = g1 ? 1 : 0;
          it.src = g1 ? int'(s1) : int'(s0);
          it.dst = g1 ? int'(d1) : int'(d0);
          it.acc = cyc;
          q.push_back(it);
          ptr = it.id;
          next_idle = cyc + 4;
          last_acc = cyc;
          if (g0) pend0 = 1'b0; else pend1 = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
          q.delete();
          ptr = 1;
          next_idle = cyc;
        end
      end
      rst = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk(NG, "queue_drained", q.size(), 0);
      fin = 1'b1;
    end

    // Monitor: expected outputs derived from the scoreboard head.
    initial begin : mon
      xfer_t          h;
      logic [NG2-1:0] ew, es;
      bit             eb, ed;
      forever begin
        @(negedge clk);
        if (cyc >= 1 && !fin) begin
          ew = '0; es = '0; eb = 1'b0; ed = 1'b0;
          if (q.size() > 0 && cyc > q[0].acc && cyc <= q[0].acc + 3) begin
            h = q[0];
            eb = 1'b1;
            ew[h.src] = 1'b1;
            if (cyc == h.acc + 2 && h.src != h.dst) es[h.dst] = 1'b1;
            if (cyc == h.acc + 3) ed = 1'b1;
          end
          chk(NG, "we", we, ew);
          chk(NG, "ws", ws, es);
          chk(NG, "busy", busy, eb);
          chk(NG, "done", done, ed);
          chk(NG, "we_onehot", ($countones(we) <= 1), 1);
          chk(NG, "ws_onehot", ($countones(ws) <= 1), 1);
          if (ed) begin
            chk(NG, "done_id", done_id, h.id);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin : top
    int k;
    for (k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (cfg[0].fin && cfg[1].fin) break;
    end
    n_cmp++;
    if (!(cfg[0].fin && cfg[1].fin)) begin
      n_fail++;
      $display("FAIL timeout actual=%0d cycles required=<20000", k);
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
